// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - borrow_in, DIGIT bits per clock, LSB digit first.
// Operands are captured on start; results, borrow and flags update only on the completion edge.
module serial_subtractor #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             overflow
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             c_q, c_d;
    logic             busy_d, done_d, borrow_d, zero_d, overflow_d;
    logic [WIDTH-1:0] diff_d;

    logic [DIGIT-1:0] dig;
    logic [DIGIT:0]   chain;
    logic [WIDTH-1:0] result;

    // Full-subtractor ripple across the current low digit.
    always_comb begin
        chain    = '0;
        dig      = '0;
        chain[0] = c_q;
        for (int i = 0; i < int'(DIGIT); i++) begin
            dig[i]     = a_q[i] ^ b_q[i] ^ chain[i];
            chain[i+1] = (~a_q[i] & chain[i]) | (~a_q[i] & b_q[i]) | (b_q[i] & chain[i]);
        end
    end

    // Earlier digits accumulate from the top; the final digit completes the word.
    if (N == 1) begin : g_single
        assign result = dig;
    end else begin : g_multi
        localparam int unsigned PW = WIDTH - DIGIT;
        logic [PW-1:0] part_q;
        logic [PW-1:0] part_nxt;

        if (N == 2) begin : g_two
            assign part_nxt = dig;
        end else begin : g_deep
            assign part_nxt = {dig, part_q[PW-1:DIGIT]};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                part_q <= '0;
            end else if (state_q == RUN) begin
                part_q <= part_nxt;
            end
        end

        assign result = {dig, part_q};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        busy_d     = busy;
        done_d     = 1'b0;
        diff_d     = diff;
        borrow_d   = borrow_out;
        zero_d     = zero;
        overflow_d = overflow;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    a_d     = a;
                    b_d     = b;
                    c_d     = borrow_in;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                c_d   = chain[DIGIT];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    // Top digit is in the low bits now, so a_q/b_q[DIGIT-1] are the operand sign bits.
                    state_d    = IDLE;
                    cnt_d      = '0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    diff_d     = result;
                    borrow_d   = chain[DIGIT];
                    zero_d     = (result == '0);
                    overflow_d = (a_q[DIGIT-1] != b_q[DIGIT-1]) && (result[WIDTH-1] != a_q[DIGIT-1]);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            zero       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            busy       <= busy_d;
            done       <= done_d;
            diff       <= diff_d;
            borrow_out <= borrow_d;
            zero       <= zero_d;
            overflow   <= overflow_d;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor across several WIDTH/DIGIT configurations.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        bin;
    logic [31:0] a_in, b_in;

    logic [15:0] df0, df1, df2;
    logic [7:0]  df3;
    logic [31:0] df4;
    logic [4:0]  dn, bs, bo, zr, ov;
    logic [31:0] dfw [5];

    int n_cmp = 0;
    int n_err = 0;

    int unsigned nlat [5] = '{4, 16, 1, 4, 4};
    int unsigned wid  [5] = '{16, 16, 16, 8, 32};

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(16), .DIGIT(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a_in[15:0]), .b(b_in[15:0]), .borrow_in(bin),
        .busy(bs[0]), .done(dn[0]), .diff(df0), .borrow_out(bo[0]), .zero(zr[0]), .overflow(ov[0]));
    serial_subtractor #(.WIDTH(16), .DIGIT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a_in[15:0]), .b(b_in[15:0]), .borrow_in(bin),
        .busy(bs[1]), .done(dn[1]), .diff(df1), .borrow_out(bo[1]), .zero(zr[1]), .overflow(ov[1]));
    serial_subtractor #(.WIDTH(16), .DIGIT(16)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a_in[15:0]), .b(b_in[15:0]), .borrow_in(bin),
        .busy(bs[2]), .done(dn[2]), .diff(df2), .borrow_out(bo[2]), .zero(zr[2]), .overflow(ov[2]));
    serial_subtractor #(.WIDTH(8), .DIGIT(2)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a_in[7:0]), .b(b_in[7:0]), .borrow_in(bin),
        .busy(bs[3]), .done(dn[3]), .diff(df3), .borrow_out(bo[3]), .zero(zr[3]), .overflow(ov[3]));
    serial_subtractor #(.WIDTH(32), .DIGIT(8)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a_in), .b(b_in), .borrow_in(bin),
        .busy(bs[4]), .done(dn[4]), .diff(df4), .borrow_out(bo[4]), .zero(zr[4]), .overflow(ov[4]));

    always_comb begin
        dfw[0] = {16'd0, df0};
        dfw[1] = {16'd0, df1};
        dfw[2] = {16'd0, df2};
        dfw[3] = {24'd0, df3};
        dfw[4] = df4;
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bi;
        logic [15:0] d;
        logic        bo;
        logic        z;
        logic        o;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic at the instance width.
    function automatic void model(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                                  input logic bi, output logic [31:0] d, output logic brw,
                                  output logic z, output logic o);
        logic [63:0] m, am, bm, full;
        m    = (64'd1 << w) - 64'd1;
        am   = {32'd0, a} & m;
        bm   = {32'd0, b} & m;
        full = am - bm - 64'(bi);
        d    = 32'(full & m);
        brw  = am < (bm + 64'(bi));
        z    = (d == 32'd0);
        o    = (a[w-1] != b[w-1]) && (d[w-1] != a[w-1]);
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bi);
        int nd [5];
        int lat [5];
        logic [31:0] ed;
        logic eb, ez, eo;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        bin   = bi;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            nd[i]  = 0;
            lat[i] = -1;
        end
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            for (int i = 0; i < 5; i++) begin
                if (dn[i]) begin
                    nd[i]++;
                    lat[i] = c;
                    model(wid[i], a, b, bi, ed, eb, ez, eo);
                    chk("diff", i, dfw[i], ed);
                    chk("borrow_out", i, 32'(bo[i]), 32'(eb));
                    chk("zero", i, 32'(zr[i]), 32'(ez));
                    chk("overflow", i, 32'(ov[i]), 32'(eo));
                    chk("busy_at_done", i, 32'(bs[i]), 32'd0);
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            chk("done_count", i, 32'(nd[i]), 32'd1);
            chk("latency", i, 32'(lat[i]), 32'(nlat[i]));
        end
    endtask

    function automatic logic [31:0] hs_a(input int k);
        return 32'h1000 + 32'(k) * 32'h111;
    endfunction

    function automatic logic [31:0] hs_b(input int k);
        return 32'(k) * 32'd3;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t_done[$];
        logic [31:0] d_done[$];
        int          cnt;

        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{16'h00F0, 16'h000F, 1'b0, 16'h00E1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        bin   = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("reset_diff", i, dfw[i], 32'd0);
            chk("reset_busy", i, 32'(bs[i]), 32'd0);
            chk("reset_done", i, 32'(dn[i]), 32'd0);
            chk("reset_flags", i, {29'd0, bo[i], zr[i], ov[i]}, 32'd0);
        end
        rst_n = 1'b1;

        // Directed vectors, hand-computed for the 16/4 configuration.
        for (int v = 0; v < 7; v++) begin
            run_op({16'd0, vecs[v].a}, {16'd0, vecs[v].b}, vecs[v].bi);
            chk("vec_diff", v, dfw[0], {16'd0, vecs[v].d});
            chk("vec_flags", v, {29'd0, bo[0], zr[0], ov[0]}, {29'd0, vecs[v].bo, vecs[v].z, vecs[v].o});
        end

        // start held for 10 edges with changing operands: accepts at t0 and in the done cycle t5.
        @(negedge clk);
        a_in  = hs_a(0);
        b_in  = hs_b(0);
        bin   = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (c == 0) chk("hs_busy", 0, 32'(bs[0]), 32'd1);
            if (dn[0]) begin
                t_done.push_back(c);
                d_done.push_back(dfw[0]);
            end
            if (c == 7) chk("hs_hold", 0, dfw[0], 32'h0000_1000);
            if (c + 1 < 10) begin
                a_in = hs_a(c + 1);
                b_in = hs_b(c + 1);
            end else begin
                start = 1'b0;
            end
        end
        chk("hs_done_count", 0, 32'(t_done.size()), 32'd2);
        if (t_done.size() >= 2) begin
            chk("hs_first_time", 0, 32'(t_done[0]), 32'd4);
            chk("hs_first_diff", 0, d_done[0], 32'h0000_1000);
            chk("hs_second_time", 0, 32'(t_done[1]), 32'd9);
            chk("hs_second_diff", 0, d_done[1], 32'h0000_1546);
        end
        repeat (25) @(negedge clk);

        // Abort after two of four digits.
        a_in  = 32'h0000_1234;
        b_in  = 32'h0000_0234;
        bin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("abort_diff", i, dfw[i], 32'd0);
            chk("abort_busy_done", i, {30'd0, bs[i], dn[i]}, 32'd0);
            chk("abort_flags", i, {29'd0, bo[i], zr[i], ov[i]}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (dn[0]) cnt++;
        end
        chk("abort_no_done", 0, 32'(cnt), 32'd0);
        run_op(32'h0000_00F0, 32'h0000_000F, 1'b0);
        chk("after_abort_diff", 0, dfw[0], 32'h0000_00E1);

        // Random sweep across all configurations.
        for (int k = 0; k < 1000; k++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
